// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_os
// Purpose  : Oversampling UART receiver with 3-sample majority vote and a
//            valid/ack word handshake. Optional parity: UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_os #(
  parameter int CLKFREQ    = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int ODD_PARITY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RxD,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ack,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun,
  output logic                  rx_idle
);

  localparam int DIV_RAW = CLKFREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SAMP_A    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_B    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SAMP_C    = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ARM    = 3'd0,
    IDLE   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd5
  } state_t;

  state_t                state, state_next;
  logic                  sync1, sync2;
  logic [1:0]            flush;
  logic [CW-1:0]         tick_cnt;
  logic [SW-1:0]         samp_cnt;
  logic                  tick;
  logic                  vote_a, vote_b, voted;
  logic                  start_go, in_frame, bit_rdy, last_bit, frame_done;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      flush <= 2'b00;
    end else begin
      sync1 <= RxD;
      sync2 <= sync1;
      flush <= {flush[0], 1'b1};
    end
  end

  assign start_go = (state == IDLE) && !sync2;
  assign tick     = (tick_cnt == TICK_LAST);

  // Both counters restart on the start edge so sampling is centred on each bit
  always_ff @(posedge clk) begin
    if (reset || start_go) begin
      tick_cnt <= '0;
      samp_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      samp_cnt <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vote_a <= 1'b1;
      vote_b <= 1'b1;
    end else if (tick) begin
      if (samp_cnt == SAMP_A) vote_a <= sync2;
      if (samp_cnt == SAMP_B) vote_b <= sync2;
    end
  end

  assign voted      = (vote_a & vote_b) | (vote_a & sync2) | (vote_b & sync2);
  assign in_frame   = (state != ARM) && (state != IDLE);
  assign bit_rdy    = tick && (samp_cnt == SAMP_C) && in_frame;
  assign last_bit   = (bit_cnt == BIT_LAST);
  assign frame_done = bit_rdy && (state == STOP);
  assign rx_idle    = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= ARM;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      // The synchroniser's reset value says nothing about the line; wait for it to flush
      ARM:   if (flush[1] && sync2) state_next = IDLE;
      IDLE:  if (!sync2) state_next = START;
      START: if (bit_rdy) state_next = voted ? IDLE : DATA;
      DATA: begin
        if (bit_rdy && last_bit) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bit_rdy) state_next = STOP;
`endif
      STOP:  if (bit_rdy) state_next = voted ? IDLE : ARM;
      default: state_next = ARM;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_bad;
  assign par_bad = ((^shreg) ^ par_bit) != ODD_PARITY[0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else if (bit_rdy) begin
      if (state == START) bit_cnt <= '0;
      if (state == DATA) begin
        shreg   <= {voted, shreg[DATA_WIDTH-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      if (state == PARITY) par_bit <= voted;
`endif
    end
  end

  // A completing frame wins over an ack in the same cycle; otherwise it is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (frame_done && (!data_valid || data_ack)) begin
      data_out   <= shreg;
      data_valid <= 1'b1;
      frame_err  <= !voted;
      overrun    <= 1'b0;
    end else if (frame_done) begin
      overrun    <= 1'b1;
    end else if (data_valid && data_ack) begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset)                                        parity_err <= 1'b0;
    else if (frame_done && (!data_valid || data_ack)) parity_err <= par_bad;
    else if (!frame_done && data_valid && data_ack)   parity_err <= 1'b0;
  end
`else
  assign parity_err = 1'b0 & ODD_PARITY[0];
`endif

endmodule
`default_nettype wire
